he_secded_encoder: RTL
======================

// Module: he_secded_encoder
// PURPOSE
//  Parametrised streaming Hamming encoder, successor to the fixed K=4/M=3 parity generator.
//  Accepts K-bit data words over a valid/ready handshake and emits full N-bit codewords,
//  parity bits interleaved at power-of-two positions.
//  Optional overall-parity bit gives SECDED (single-error-correct, double-error-detect).
//  Sits between the payload source and the memory/link write port; the he decoder consumes its output.
// PARAMETERS
//  K      4   data bits per word (>=1)
//  M      3   Hamming parity bits; elaboration must $error if 2**M < K+M+1
//  SECDED 1   1: append overall parity bit at MSB; 0: plain Hamming
//  CW     16  width of the saturating encoded-word counter
//  (derived) N = K+M+SECDED codeword width
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous active-low reset
//  in_valid   in   1      din valid
//  in_ready   out  1      encoder can accept din this cycle
//  din        in   K      data word
//  inj_en     in   1      error injection enable, sampled with din on accept
//  inj_mask   in   N      bits XORed into the codeword when inj_en=1
//  out_valid  out  1      code valid
//  out_ready  in   1      downstream accepts code
//  code       out  N      codeword; code[p-1] = Hamming position p; code[N-1] = overall parity if SECDED
//  word_cnt   out  CW     count of codewords delivered (out_valid&&out_ready), saturating
//  clr_cnt    in   1      synchronous clear of word_cnt
// BEHAVIOUR
//  Reset (rst=0, async): out_valid=0, code=0, word_cnt=0, buffer empty, in_ready=1 one cycle after release.
//  Layout: positions 1..K+M; powers of two hold parity, the rest hold din[0..K-1] in ascending order.
//  Parity bit 2**i = XOR of all data positions j with j[i]=1.
//  Overall bit (SECDED=1) = XOR of bits code[K+M-1:0] before injection.
//  Injection: code_out = code_clean ^ (inj_en ? inj_mask : 0); applied once, at accept, per word.
//  Accept: in_valid && in_ready at edge t -> word visible on code/out_valid from edge t (latency 1 cycle).
//  Buffer: 2-entry FIFO (skid) between encode stage and output.
//   - in_ready = (occupancy < 2), driven from registered occupancy only; no combinational path from out_ready.
//   - code/out_valid come from the head entry, registered; code holds stable while out_valid && !out_ready.
//   - Simultaneous accept and deliver: occupancy unchanged; order strictly FIFO.
//   - Full (2): in_ready=0; in_valid ignored, din not sampled.
//   - Empty: out_valid=0, code holds last delivered value (not X).
//  Occupancy transitions 0->1 (acc), 1->2 (acc, no deliver), 2->1 (deliver), 1->0 (deliver, no acc).
//  word_cnt: +1 per delivery, saturates at 2**CW-1.
//   - clr_cnt has priority over increment: cleared count reads 0 next cycle.
//  Reset mid-operation: buffered words discarded, no partial output; in_ready=0 while rst=0.
//  Encoding is purely combinational into the buffer entry; no multicycle paths.
// TESTING  (K=4, M=3, SECDED=1 unless noted)
//  1 din=4'b1011, out_ready=1, inj_en=0 -> next cycle code=8'h55, out_valid=1, word_cnt=1.
//  2 din=4'hF then 4'h0 back-to-back -> code=8'hFF then 8'h00 on consecutive cycles, in_ready stays 1.
//  3 out_ready=0, three valid words offered -> first two accepted, in_ready=0 on third, code stable;
//    release out_ready -> 2 words delivered in order, third then accepted.
//  4 din=4'b1011, inj_en=1, inj_mask=8'h04 -> code=8'h51; mask 8'h05 -> code=8'h50 (double error).
//  5 rst pulsed low with 2 words buffered -> out_valid=0, word_cnt=0 same cycle; no stale word after release.
//  6 K=11, M=4, SECDED=0 -> 15-bit code matches reference model over 2000 random words under random
//    valid/ready; CW=4 word_cnt saturates at 15; clr_cnt with delivery -> 0.

Source files
------------

// File: rtl/he_secded_encoder_if.sv
// rtl/he_secded_encoder_if.sv - stream bundle between payload source, encoder and write port
// Input word stream, injection controls, output codeword stream and delivered-word counter.
interface he_secded_encoder_if #(
   parameter int K  = 4,
   parameter int N  = 8,
   parameter int CW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [K-1:0]  din;
   logic          inj_en;
   logic [N-1:0]  inj_mask;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  code;
   logic [CW-1:0] word_cnt;
   logic          clr_cnt;

   modport master (
      output in_valid, din, inj_en, inj_mask, out_ready, clr_cnt,
      input  in_ready, out_valid, code, word_cnt
   );

   modport slave (
      input  in_valid, din, inj_en, inj_mask, out_ready, clr_cnt,
      output in_ready, out_valid, code, word_cnt
   );
endinterface

// File: rtl/he_secded_encoder.sv
// rtl/he_secded_encoder.sv - streaming Hamming/SECDED encoder with 2-entry output skid buffer
// Codeword bit p-1 is Hamming position p; optional overall parity sits at the MSB.
module he_secded_encoder #(
   parameter int K      = 4,
   parameter int M      = 3,
   parameter int SECDED = 1,
   parameter int CW     = 16
) (
   input logic               clk,
   input logic               rst,
   he_secded_encoder_if.slave bus
);
   localparam int H = K + M;
   localparam int N = H + SECDED;

   if ((1 << M) < K + M + 1) begin : g_bad_params
      $error("he_secded_encoder: M too small for K");
   end

   function automatic bit is_pow2(input int p);
      return (p & (p - 1)) == 0;
   endfunction

   function automatic int data_idx(input int p);
      int c;
      c = 0;
      for (int q = 1; q < p; q++) begin
         if (!is_pow2(q)) c++;
      end
      return c;
   endfunction

   function automatic logic [H-1:0] par_mask(input int i);
      logic [H-1:0] m;
      m = '0;
      for (int p = 1; p <= H; p++) begin
         if (!is_pow2(p) && ((p >> i) & 1) != 0) m = m | (H'(1) << (p - 1));
      end
      return m;
   endfunction

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} occ_t;

   occ_t         r_state;
   occ_t         w_state_nxt;
   logic         r_live;
   logic [N-1:0] r_head;
   logic [N-1:0] r_tail;
   logic [CW-1:0] r_cnt;

   logic [H-1:0] w_dpos;
   logic [H-1:0] w_ham;
   logic [M-1:0] w_par;
   logic [N-1:0] w_clean;
   logic [N-1:0] w_code;
   logic         w_in_ready;
   logic         w_out_valid;
   logic         w_acc;
   logic         w_del;
   logic         w_ld_head;
   logic         w_ld_tail;
   logic         w_head_from_tail;

   // w_dpos carries only the data bits in place, so each parity is a masked reduction of it
   for (genvar p = 1; p <= H; p++) begin : g_pos
      if (is_pow2(p)) begin : g_parity
         assign w_dpos[p-1] = 1'b0;
         assign w_ham[p-1]  = w_par[$clog2(p)];
      end else begin : g_data
         assign w_dpos[p-1] = bus.din[data_idx(p)];
         assign w_ham[p-1]  = w_dpos[p-1];
      end
   end

   for (genvar i = 0; i < M; i++) begin : g_par
      assign w_par[i] = ^(w_dpos & par_mask(i));
   end

   if (SECDED != 0) begin : g_secded
      assign w_clean = {^w_ham, w_ham};
   end else begin : g_plain
      assign w_clean = w_ham;
   end

   assign w_code = w_clean ^ (bus.inj_en ? bus.inj_mask : '0);

   // r_live keeps in_ready low during reset and for the first cycle after release
   assign w_in_ready  = r_live && (r_state != S_FULL);
   assign w_out_valid = (r_state != S_EMPTY);
   assign w_acc       = bus.in_valid && w_in_ready;
   assign w_del       = w_out_valid && bus.out_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_ld_head        = 1'b0;
      w_ld_tail        = 1'b0;
      w_head_from_tail = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_acc) begin
               w_state_nxt = S_ONE;
               w_ld_head   = 1'b1;
            end
         end
         S_ONE: begin
            if (w_acc && w_del) begin
               w_ld_head = 1'b1;
            end else if (w_acc) begin
               w_state_nxt = S_FULL;
               w_ld_tail   = 1'b1;
            end else if (w_del) begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_FULL: begin
            if (w_del) begin
               w_state_nxt      = S_ONE;
               w_head_from_tail = 1'b1;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_live <= 1'b0;
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_ld_head) begin
            r_head <= w_code;
         end else if (w_head_from_tail) begin
            r_head <= r_tail;
         end
         if (w_ld_tail) r_tail <= w_code;
         if (bus.clr_cnt) begin
            r_cnt <= '0;
         end else if (w_del && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.code      = r_head;
   assign bus.word_cnt  = r_cnt;
endmodule
